// File: rtl/mux_pkg.sv
// Shared types and helpers for the registered scanning N-to-1 multiplexer.
package mux_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMan,
        StScan
    } state_e;

    // Channel index increment that wraps to 0 after n-1 (n need not be a power of two).
    function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned n);
        return (p + 32'd1 >= n) ? 32'd0 : p + 32'd1;
    endfunction

endpackage

// File: rtl/mux_nx1.sv
// Purely combinational N-to-1 selector of W-bit channels; out-of-range select yields zero.
module mux_nx1 #(
    parameter int unsigned N     = 16,
    parameter int unsigned W     = 8,
    parameter int unsigned SEL_W = $clog2(N)
) (
    input  logic [N*W-1:0] data_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [W-1:0]   data_o
);

    always_comb begin
        data_o = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (sel_i == SEL_W'(k)) begin
                data_o = data_i[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered N-to-1 mux with valid/ready output, manual single-shot and auto-scan modes.
module mux_scan_nx1
    import mux_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned W     = 8,
    parameter int unsigned SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   i,
    input  logic [SEL_W-1:0] s,
    input  logic             mode,
    input  logic             req,
    output logic [W-1:0]     y,
    output logic [SEL_W-1:0] y_sel,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned CntW = $clog2(N + 1);

    state_e            state_q;
    logic [W-1:0]      y_q;
    logic [SEL_W-1:0]  y_sel_q;
    logic              y_valid_q;
    logic [CntW-1:0]   cnt_q;
    logic              done_q;
    logic              err_q;

    logic              s_oob;
    logic [SEL_W-1:0]  p0;
    logic [SEL_W-1:0]  next_sel;
    logic [SEL_W-1:0]  mux_sel;
    logic [W-1:0]      mux_data;
    logic              accept;
    logic              last;

    always_comb begin
        s_oob    = (32'(s) >= N);
        p0       = s_oob ? '0 : s;
        next_sel = SEL_W'(wrap_inc(32'(y_sel_q), N));
        // Idle selects the requested channel; manual out-of-range s makes the selector return 0.
        mux_sel  = (state_q == StIdle) ? (mode ? p0 : s) : next_sel;
        accept   = y_valid_q && y_ready;
        last     = (cnt_q == CntW'(N));
    end

    mux_nx1 #(
        .N     (N),
        .W     (W),
        .SEL_W (SEL_W)
    ) u_sel (
        .data_i (i),
        .sel_i  (mux_sel),
        .data_o (mux_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            y_q       <= '0;
            y_sel_q   <= '0;
            y_valid_q <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        y_q       <= mux_data;
                        y_valid_q <= 1'b1;
                        if (mode) begin
                            y_sel_q <= p0;
                            cnt_q   <= CntW'(1);
                            state_q <= StScan;
                        end else begin
                            y_sel_q <= s;
                            err_q   <= s_oob;
                            state_q <= StMan;
                        end
                    end
                end
                StMan: begin
                    if (accept) begin
                        y_valid_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                StScan: begin
                    if (accept) begin
                        if (last) begin
                            y_valid_q <= 1'b0;
                            done_q    <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= StIdle;
                        end else begin
                            y_q     <= mux_data;
                            y_sel_q <= next_sel;
                            cnt_q   <= cnt_q + CntW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign y       = y_q;
    assign y_sel   = y_sel_q;
    assign y_valid = y_valid_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign err     = err_q;

endmodule
